// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digits
// and the multiplier-triplet decoder.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } digit_t;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic digit_t decode_triplet(input logic [2:0] triplet);
    digit_t digit;
    case (triplet)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Combinational radix-4 Booth selector: turns one multiplier triplet into a
// signed addend of 0, +-A or +-2A, one bit wider than the extended multiplicand.
module booth_r4_encoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       triplet,
  input  logic [WIDTH+1:0] multiplicand,
  output logic [WIDTH+2:0] addend
);

  logic [WIDTH+2:0] a_one;
  logic [WIDTH+2:0] a_two;
  digit_t           digit;

  assign a_one = {multiplicand[WIDTH+1], multiplicand};
  assign a_two = {multiplicand, 1'b0};
  assign digit = decode_triplet(triplet);

  always_comb begin
    addend = '0;
    case (digit)
      POS1:    addend = a_one;
      POS2:    addend = a_two;
      NEG1:    addend = (~a_one) + (WIDTH+3)'(1);
      NEG2:    addend = (~a_two) + (WIDTH+3)'(1);
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_radix4_mul.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, WIDTH/2+1
// cycles per product, valid/ready handshakes on both sides.
module booth_radix4_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand_a,
  input  logic [WIDTH-1:0]   multiplier_b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER);
  localparam int HW   = WIDTH + 3;
  localparam int AW   = 2 * WIDTH + 6;

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_radix4_mul: WIDTH must be even and at least 4");
    end
  endgenerate

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      count;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      stepped;
  logic [WIDTH+1:0]   mult_a;
  logic [WIDTH+1:0]   a_ext;
  logic [WIDTH+1:0]   b_ext;
  logic [HW-1:0]      addend;
  logic [HW-1:0]      sum;
  logic [2*WIDTH-1:0] product_q;

  assign a_ext = signed_mode ? {{2{multiplicand_a[WIDTH-1]}}, multiplicand_a}
                             : {2'b00, multiplicand_a};
  assign b_ext = signed_mode ? {{2{multiplier_b[WIDTH-1]}}, multiplier_b}
                             : {2'b00, multiplier_b};

  booth_r4_encoder #(.WIDTH(WIDTH)) u_encoder (
    .triplet      (acc[2:0]),
    .multiplicand (mult_a),
    .addend       (addend)
  );

  // acc = {partial sum (HW bits), remaining multiplier bits, lookahead bit}.
  assign sum     = acc[AW-1:AW-HW] + addend;
  assign stepped = $signed({sum, acc[HW-1:0]}) >>> 2;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = product_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)      state_next = CALC;
      CALC:    if (count == '0)   state_next = DONE;
      DONE:    if (out_ready)     state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      acc       <= '0;
      mult_a    <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mult_a <= a_ext;
            acc    <= {{HW{1'b0}}, b_ext, 1'b0};
            count  <= CW'(ITER - 1);
          end
        end
        CALC: begin
          acc <= stepped;
          if (count == '0) product_q <= stepped[2*WIDTH:1];
          else             count     <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_mul.sv
// Directed and randomized self-checking bench for booth_radix4_mul (WIDTH=16).
module tb_booth_radix4_mul;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] multiplicand_a;
  logic [15:0] multiplier_b;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int checks;
  int errors;

  booth_radix4_mul #(.WIDTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .multiplicand_a (multiplicand_a),
    .multiplier_b   (multiplier_b),
    .signed_mode    (signed_mode),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .product        (product),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where
  // out_valid is first seen, with lat = rising edges after the accept edge.
  task automatic applyStimulus(input logic [15:0] a_in, input logic [15:0] b_in,
                               input logic mode, output int lat);
    multiplicand_a = a_in;
    multiplier_b   = b_in;
    signed_mode    = mode;
    in_valid       = 1'b1;
    @(posedge clk);
    #1;
    in_valid       = 1'b0;
    multiplicand_a = ~a_in;
    multiplier_b   = b_in ^ 16'h5A5A;
    signed_mode    = ~mode;
    checkOutput("busy_in_calc", {63'd0, busy}, 64'd1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic finishOp();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] held;
    logic        seen;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rm;
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    longint      full;
    logic [31:0] expect_p;
    int          n;

    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    multiplicand_a = '0;
    multiplier_b   = '0;
    signed_mode    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_product", {32'd0, product}, 64'd0);

    // Most negative signed operands and latency
    applyStimulus(16'h8000, 16'h8000, 1'b1, lat);
    checkOutput("min_min_latency", 64'(lat), 64'd9);
    checkOutput("min_min_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("min_min_product", {32'd0, product}, 64'h4000_0000);
    finishOp();
    checkOutput("after_hs_in_ready", {63'd0, in_ready}, 64'd1);

    // Same bits, signed versus unsigned
    applyStimulus(16'hFFFF, 16'h0001, 1'b1, lat);
    checkOutput("neg1_x_1_signed", {32'd0, product}, 64'hFFFF_FFFF);
    finishOp();
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, lat);
    checkOutput("ffff_x_1_unsigned", {32'd0, product}, 64'h0000_FFFF);
    finishOp();

    // Unsigned max squared, then back-pressure with stray in_valid
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, lat);
    checkOutput("ffff_sq_unsigned", {32'd0, product}, 64'hFFFE_0001);
    held           = product;
    in_valid       = 1'b1;
    multiplicand_a = 16'h1234;
    multiplier_b   = 16'h5678;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_out_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("hold_product", {32'd0, product}, {32'd0, held});
      checkOutput("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    finishOp();
    checkOutput("idle_product_kept", {32'd0, product}, 64'hFFFE_0001);

    // Reset during the 4th CALC cycle
    multiplicand_a = 16'h7FFF;
    multiplier_b   = 16'h7FFF;
    signed_mode    = 1'b1;
    in_valid       = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midcalc_rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("midcalc_rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midcalc_rst_product", {32'd0, product}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("midcalc_no_pulse", {63'd0, seen}, 64'd0);
    applyStimulus(16'h0003, 16'hFFFD, 1'b1, lat);
    checkOutput("three_x_neg3", {32'd0, product}, 64'hFFFF_FFF7);

    // Reset beats the output handshake in DONE
    out_ready = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b0;
    checkOutput("done_rst_product", {32'd0, product}, 64'd0);
    checkOutput("done_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Back-to-back random operations
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = 1'($urandom_range(0, 1));
      if (rm) begin
        sa   = ra;
        sb   = rb;
        full = longint'(sa) * longint'(sb);
      end else begin
        full = longint'(ra) * longint'(rb);
      end
      expect_p       = full[31:0];
      multiplicand_a = ra;
      multiplier_b   = rb;
      signed_mode    = rm;
      in_valid       = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid && n < 40);
      checkOutput("b2b_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("b2b_product", {32'd0, product}, {32'd0, expect_p});
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
